// File: rtl/posit_decoder_param.sv
// Parametrised multi-cycle posit decoder: N-bit posit with ES exponent bits in,
// sign/k/exponent/hidden-bit mantissa/fraction length out.
// Ports: clk, rst (sync, active-high); start/posit_num request; busy/done/received handshake;
//        sign, ZERO, NAR, k (signed), exp_value, mantissa, frac_len results.
module posit_decoder_param #(
  parameter int N  = 32,
  parameter int ES = 2,
  localparam int KW = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         posit_num,
  input  logic                 received,
  output logic                 busy,
  output logic                 done,
  output logic                 sign,
  output logic                 ZERO,
  output logic                 NAR,
  output logic signed [KW-1:0] k,
  output logic [ES-1:0]        exp_value,
  output logic [N-1:0]         mantissa,
  output logic [KW-1:0]        frac_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REGIME, S_EXP, S_FRAC, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  hold;
  logic [KW-1:0] run;
  logic [KW-1:0] rem;
  logic          r0;

  logic          is_zero, is_nar;
  logic [N-1:0]  neg_word, mag;
  logic          r0_eff, bit_eq, reg_end;
  logic [KW-1:0] run_nxt, rem_nxt, k_nxt;

  // Helper datapath terms
  always_comb begin
    is_zero  = (hold == '0);
    is_nar   = (hold == {1'b1, {(N-1){1'b0}}});
    neg_word = -hold;
    mag      = hold[N-1] ? neg_word : hold;
    // The very first regime bit (run still 0) defines the run polarity.
    r0_eff   = (run == '0) ? hold[N-1] : r0;
    bit_eq   = (hold[N-1] == r0_eff);
    run_nxt  = bit_eq ? run + KW'(1) : run;
    rem_nxt  = rem - KW'(1);
    // Leave on the terminator or when the word runs out (unterminated regime).
    reg_end  = !bit_eq || (rem_nxt == '0);
    k_nxt    = r0_eff ? run_nxt - KW'(1) : -run_nxt;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = (is_zero || is_nar) ? S_DONE : S_REGIME;
      S_REGIME: if (reg_end) state_nxt = S_EXP;
      S_EXP:    state_nxt = S_FRAC;
      S_FRAC:   state_nxt = S_DONE;
      S_DONE:   if (received) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      run       <= '0;
      rem       <= '0;
      r0        <= 1'b0;
      sign      <= 1'b0;
      ZERO      <= 1'b0;
      NAR       <= 1'b0;
      k         <= '0;
      exp_value <= '0;
      mantissa  <= '0;
      frac_len  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            hold <= posit_num;
            ZERO <= 1'b0;
            NAR  <= 1'b0;
          end
        end
        S_CHECK: begin
          if (is_zero || is_nar) begin
            ZERO      <= is_zero;
            NAR       <= is_nar;
            sign      <= 1'b0;
            k         <= '0;
            exp_value <= '0;
            mantissa  <= '0;
            frac_len  <= '0;
          end else begin
            sign <= hold[N-1];
            // Drop the sign bit so the regime starts at the MSB.
            hold <= mag << 1;
            rem  <= KW'(N-1);
            run  <= '0;
          end
        end
        S_REGIME: begin
          r0   <= r0_eff;
          run  <= run_nxt;
          rem  <= rem_nxt;
          hold <= hold << 1;
          if (reg_end) k <= k_nxt;
        end
        S_EXP: begin
          // Bits beyond the word were shifted in as zeros, so a truncated
          // exponent reads its missing low bits as zero.
          exp_value <= hold[N-1 -: ES];
          hold      <= hold << ES;
          rem       <= (rem > KW'(ES)) ? rem - KW'(ES) : '0;
        end
        S_FRAC: begin
          mantissa <= {1'b1, hold[N-1:1]};
          frac_len <= rem;
        end
        default: ;
      endcase
    end
  end

endmodule
